systolic_result_drain: RTL and testbench

Read-side companion to the 4x4 MAC processing-element array. Snapshots the N×N accumulator outputs (C) of all PEs on a capture pulse. Then streams them out one word per handshake in row-major order over a valid/ready interface. Issues a one-cycle clear to the PE accumulators so the next matrix product can start while the drain is still streaming.

---
 rtl/systolic_result_drain_if.sv | 48 ++++
 rtl/systolic_result_drain.sv | 116 +++++++++++
 tb/tb_systolic_result_drain.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_result_drain_if.sv
// ---------------------------------------------------------------------------
// systolic_result_drain_if
//
// Purpose: result stream carried from the systolic result drain to its
// consumer. Each word is tagged with the (row, col) position of the PE it
// came from, and the final word of a frame is marked with out_last.
//
// Signals:
//   out_data   DW bits        result word
//   out_valid  1              out_data holds a valid word
//   out_ready  1              consumer accepts the word this cycle
//   out_row    clog2(N) bits  row index of out_data
//   out_col    clog2(N) bits  column index of out_data
//   out_last   1              word is the final one of the frame
//
// Modports: master (drain side), slave (consumer side).
// ---------------------------------------------------------------------------
interface systolic_result_drain_if #(
  parameter int N  = 4,
  parameter int DW = 16
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic [RW-1:0] out_col;
  logic          out_last;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready,
    output out_row,
    output out_col,
    output out_last
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_row,
    input  out_col,
    input  out_last
  );
endinterface

// File: rtl/systolic_result_drain.sv
// ---------------------------------------------------------------------------
// systolic_result_drain
//
// Purpose: read-side companion to the N x N MAC processing-element array.
// A capture pulse snapshots every PE accumulator into a local buffer and
// fires a one-cycle clear back at the array, so the next product can start
// accumulating while this block streams the held results out in row-major
// order, one word per valid/ready handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   c_in       in   N*N*DW flattened accumulators, (r,c) at [(r*N+c)*DW +: DW]
//   capture    in   one-cycle snapshot request
//   stream     master modport of systolic_result_drain_if (result stream)
//   array_clr  out  one-cycle pulse clearing the PE accumulators
//   busy       out  a snapshot is held and being streamed
//   overrun    out  sticky flag: capture seen while busy
// ---------------------------------------------------------------------------
module systolic_result_drain #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*N*DW-1:0]       c_in,
  input  logic                    capture,
  systolic_result_drain_if.master stream,
  output logic                    array_clr,
  output logic                    busy,
  output logic                    overrun
);

  localparam int NW   = N * N;
  localparam int RW   = (N > 1) ? $clog2(N) : 1;
  localparam int IDXW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NW - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t          state_q;
  logic [IDXW-1:0] index_q;
  logic [DW-1:0]   snap_q [NW];
  logic            valid_q;
  logic            clr_q;
  logic            overrun_q;

  // Control FSM and snapshot buffer. A capture is only honoured in IDLE; the
  // cycle of the final transfer still counts as busy, so a capture there is
  // flagged as an overrun instead of being taken. The buffer is written only
  // on an accepted capture, which keeps the stream isolated from c_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      index_q   <= '0;
      valid_q   <= 1'b0;
      clr_q     <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      clr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (capture) begin
            for (int i = 0; i < NW; i++) begin
              snap_q[i] <= c_in[i*DW +: DW];
            end
            index_q <= '0;
            state_q <= STREAM;
            valid_q <= 1'b1;
            clr_q   <= 1'b1;
          end
        end
        STREAM: begin
          if (capture) begin
            overrun_q <= 1'b1;
          end
          // valid_q is always set in STREAM, so ready alone marks a transfer.
          if (stream.out_ready) begin
            if (index_q == LAST_IDX) begin
              state_q <= IDLE;
              index_q <= '0;
              valid_q <= 1'b0;
            end else begin
              index_q <= index_q + IDXW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          index_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Stream outputs come straight from registered state, so they hold steady
  // under backpressure without any extra staging. After reset the buffer is
  // zero and the index is zero, so out_data reads 0 until the next capture.
  assign stream.out_valid = valid_q;
  assign stream.out_data  = snap_q[index_q];
  assign stream.out_row   = RW'(index_q / IDXW'(N));
  assign stream.out_col   = RW'(index_q % IDXW'(N));
  assign stream.out_last  = valid_q && (index_q == LAST_IDX);

  assign array_clr = clr_q;
  assign busy      = (state_q == STREAM);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// ---------------------------------------------------------------------------
// tb_systolic_result_drain
//
// Purpose: self-checking bench for systolic_result_drain. Expected words
// are queued when a capture is driven and popped whenever the DUT presents
// a word that will be accepted. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_systolic_result_drain;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int NW = N * N;

  logic              clk = 1'b0;
  logic              rst;
  logic [NW*DW-1:0]  cIn;
  logic              capture;
  logic              arrayClr;
  logic              busy;
  logic              overrun;

  systolic_result_drain_if #(.N(N), .DW(DW)) drainIf ();

  systolic_result_drain #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .c_in      (cIn),
    .capture   (capture),
    .stream    (drainIf),
    .array_clr (arrayClr),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          last;
  } exp_t;

  exp_t sbq[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Matrix with c(r,c) = 0x0100*r + c.
  function automatic void fill_ramp();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        cIn[(r*N+c)*DW +: DW] = DW'((r << 8) | c);
  endfunction

  // Matrix with c(r,c) = 0x8000 | (4r + c).
  function automatic void fill_high();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        cIn[(r*N+c)*DW +: DW] = DW'(16'h8000 | (4*r + c));
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < NW; i++)
      cIn[i*DW +: DW] = DW'($urandom);
  endfunction

  // Queue the expected row-major frame for whatever cIn holds right now.
  function automatic void push_frame();
    exp_t e;
    for (int i = 0; i < NW; i++) begin
      e.data = cIn[i*DW +: DW];
      e.row  = 2'(i / N);
      e.col  = 2'(i % N);
      e.last = (i == NW - 1);
      sbq.push_back(e);
    end
  endfunction

  // Reset state, and a capture held together with rst must be ignored.
  task automatic test_reset();
    rst = 1'b1;
    capture = 1'b1;
    drainIf.out_ready = 1'b1;
    fill_ramp();
    repeat (2) @(negedge clk);
    nChecks++;
    if ({drainIf.out_valid, busy, overrun, arrayClr, drainIf.out_last} !== 5'b0) begin
      nFails++;
      $display("[TB] FAIL reset_flags: got valid/busy/ovr/clr/last=%b expected 00000",
               {drainIf.out_valid, busy, overrun, arrayClr, drainIf.out_last});
    end
    nChecks++;
    if ({drainIf.out_data, drainIf.out_row, drainIf.out_col} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_data: got data=%h row=%0d col=%0d expected 0/0/0",
               drainIf.out_data, drainIf.out_row, drainIf.out_col);
    end
    rst = 1'b0;
    capture = 1'b0;
    @(negedge clk);
    nChecks++;
    if ({drainIf.out_valid, arrayClr, busy} !== 3'b0) begin
      nFails++;
      $display("[TB] FAIL reset_capture_ignored: got valid/clr/busy=%b expected 000",
               {drainIf.out_valid, arrayClr, busy});
    end
  endtask

  task automatic test_basic_drain();
    exp_t e;
    int   cyc = 0;
    fill_ramp();
    push_frame();
    capture = 1'b1;
    drainIf.out_ready = 1'b1;
    while (sbq.size() != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      capture = 1'b0;
      nChecks++;
      if (arrayClr !== (cyc == 1)) begin
        nFails++;
        $display("[TB] FAIL basic_clr cyc%0d: got %b expected %b", cyc, arrayClr, cyc == 1);
      end
      if (drainIf.out_valid && drainIf.out_ready) begin
        e = sbq.pop_front();
        nChecks++;
        if ({drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last, busy} !==
            {e.data, e.row, e.col, e.last, 1'b1}) begin
          nFails++;
          $display("[TB] FAIL basic_word cyc%0d: got %h r%0d c%0d last=%b busy=%b expected %h r%0d c%0d last=%b busy=1",
                   cyc, drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last, busy,
                   e.data, e.row, e.col, e.last);
        end
      end
    end
    nChecks++;
    if (sbq.size() != 0 || cyc != NW) begin
      nFails++;
      $display("[TB] FAIL basic_timing: got %0d words left after %0d cycles expected 0 after %0d",
               sbq.size(), cyc, NW);
      sbq.delete();
    end
    @(negedge clk);
    nChecks++;
    if ({drainIf.out_valid, busy} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL basic_end: got valid/busy=%b expected 00", {drainIf.out_valid, busy});
    end
  endtask

  task automatic test_backpressure();
    exp_t          e;
    int            cyc = 0;
    int            ph;
    logic          havePrev = 1'b0;
    logic [DW+5:0] prev = '0;
    logic [DW+5:0] cur;
    fill_ramp();
    push_frame();
    capture = 1'b1;
    drainIf.out_ready = 1'b1;
    while (sbq.size() != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      capture = 1'b0;
      ph = (cyc - 1) % 4;
      drainIf.out_ready = (ph == 0) || (ph == 3);
      cur = {drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last, drainIf.out_valid};
      if (havePrev) begin
        nChecks++;
        if (cur !== prev) begin
          nFails++;
          $display("[TB] FAIL bp_stable cyc%0d: got %h expected %h", cyc, cur, prev);
        end
      end
      havePrev = drainIf.out_valid && !drainIf.out_ready;
      prev = cur;
      if (drainIf.out_valid && drainIf.out_ready) begin
        e = sbq.pop_front();
        nChecks++;
        if ({drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last} !==
            {e.data, e.row, e.col, e.last}) begin
          nFails++;
          $display("[TB] FAIL bp_word cyc%0d: got %h r%0d c%0d last=%b expected %h r%0d c%0d last=%b",
                   cyc, drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last,
                   e.data, e.row, e.col, e.last);
        end
      end
    end
    nChecks++;
    if (sbq.size() != 0) begin
      nFails++;
      $display("[TB] FAIL bp_timeout: got %0d words left expected 0 within 40 cycles", sbq.size());
      sbq.delete();
    end
    drainIf.out_ready = 1'b1;
    @(negedge clk);
    nChecks++;
    if (drainIf.out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL bp_end: got valid=%b expected 0", drainIf.out_valid);
    end
  endtask

  task automatic test_snapshot_isolation();
    exp_t e;
    int   cyc = 0;
    fill_random();
    push_frame();
    capture = 1'b1;
    drainIf.out_ready = 1'b1;
    while (sbq.size() != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      capture = 1'b0;
      if (cyc == 1) cIn = '1;
      if (drainIf.out_valid && drainIf.out_ready) begin
        e = sbq.pop_front();
        nChecks++;
        if ({drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last} !==
            {e.data, e.row, e.col, e.last}) begin
          nFails++;
          $display("[TB] FAIL iso_word cyc%0d: got %h r%0d c%0d last=%b expected %h r%0d c%0d last=%b",
                   cyc, drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last,
                   e.data, e.row, e.col, e.last);
        end
      end
    end
    nChecks++;
    if (sbq.size() != 0) begin
      nFails++;
      $display("[TB] FAIL iso_timeout: got %0d words left expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    exp_t e;
    int   cyc = 0;
    int   widx;
    nChecks++;
    if (overrun !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL ovr_initial: got %b expected 0", overrun);
    end
    fill_ramp();
    push_frame();
    capture = 1'b1;
    drainIf.out_ready = 1'b1;
    while (sbq.size() != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      capture = 1'b0;
      nChecks++;
      if ({arrayClr, overrun} !== {cyc == 1, cyc >= 7}) begin
        nFails++;
        $display("[TB] FAIL ovr_flags cyc%0d: got clr/ovr=%b%b expected %b%b",
                 cyc, arrayClr, overrun, cyc == 1, cyc >= 7);
      end
      if (drainIf.out_valid && drainIf.out_ready) begin
        widx = NW - sbq.size();
        e = sbq.pop_front();
        nChecks++;
        if ({drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last} !==
            {e.data, e.row, e.col, e.last}) begin
          nFails++;
          $display("[TB] FAIL ovr_word cyc%0d: got %h r%0d c%0d last=%b expected %h r%0d c%0d last=%b",
                   cyc, drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last,
                   e.data, e.row, e.col, e.last);
        end
        if (widx == 5 || widx == NW - 1) capture = 1'b1;
      end
    end
    nChecks++;
    if (sbq.size() != 0) begin
      nFails++;
      $display("[TB] FAIL ovr_timeout: got %0d words left expected 0", sbq.size());
      sbq.delete();
    end
    // First idle cycle: the capture on the last transfer must have been dropped.
    @(negedge clk);
    capture = 1'b0;
    nChecks++;
    if ({drainIf.out_valid, busy, arrayClr, overrun} !== 4'b0001) begin
      nFails++;
      $display("[TB] FAIL ovr_idle: got valid/busy/clr/ovr=%b expected 0001",
               {drainIf.out_valid, busy, arrayClr, overrun});
    end
    fill_high();
    push_frame();
    capture = 1'b1;
    cyc = 0;
    while (sbq.size() != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      capture = 1'b0;
      if (drainIf.out_valid && drainIf.out_ready) begin
        e = sbq.pop_front();
        nChecks++;
        if ({drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last, overrun} !==
            {e.data, e.row, e.col, e.last, 1'b1}) begin
          nFails++;
          $display("[TB] FAIL ovr_fresh cyc%0d: got %h r%0d c%0d last=%b ovr=%b expected %h r%0d c%0d last=%b ovr=1",
                   cyc, drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last, overrun,
                   e.data, e.row, e.col, e.last);
        end
      end
    end
    nChecks++;
    if (sbq.size() != 0) begin
      nFails++;
      $display("[TB] FAIL ovr_fresh_timeout: got %0d words left expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stream();
    exp_t e;
    int   cyc = 0;
    int   popped = 0;
    fill_random();
    push_frame();
    capture = 1'b1;
    drainIf.out_ready = 1'b1;
    while (popped < 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      capture = 1'b0;
      if (drainIf.out_valid && drainIf.out_ready) begin
        e = sbq.pop_front();
        popped++;
        nChecks++;
        if ({drainIf.out_data, drainIf.out_row, drainIf.out_col} !== {e.data, e.row, e.col}) begin
          nFails++;
          $display("[TB] FAIL rst_pre_word cyc%0d: got %h r%0d c%0d expected %h r%0d c%0d",
                   cyc, drainIf.out_data, drainIf.out_row, drainIf.out_col, e.data, e.row, e.col);
        end
      end
    end
    // Word 7 transfers on the coming edge; reset is applied on the one after.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    nChecks++;
    if ({drainIf.out_valid, busy, overrun, arrayClr} !== 4'b0000 || drainIf.out_data !== '0) begin
      nFails++;
      $display("[TB] FAIL rst_mid: got valid/busy/ovr/clr=%b data=%h expected 0000 data=0000",
               {drainIf.out_valid, busy, overrun, arrayClr}, drainIf.out_data);
    end
    @(negedge clk);
    nChecks++;
    if (drainIf.out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL rst_no_resume: got valid=%b expected 0", drainIf.out_valid);
    end
    fill_ramp();
    push_frame();
    capture = 1'b1;
    cyc = 0;
    while (sbq.size() != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      capture = 1'b0;
      if (drainIf.out_valid && drainIf.out_ready) begin
        e = sbq.pop_front();
        nChecks++;
        if ({drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last} !==
            {e.data, e.row, e.col, e.last}) begin
          nFails++;
          $display("[TB] FAIL rst_restart cyc%0d: got %h r%0d c%0d last=%b expected %h r%0d c%0d last=%b",
                   cyc, drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last,
                   e.data, e.row, e.col, e.last);
        end
      end
    end
    nChecks++;
    if (sbq.size() != 0) begin
      nFails++;
      $display("[TB] FAIL rst_restart_timeout: got %0d words left expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc = 0;
    logic second = 1'b0;
    fill_ramp();
    push_frame();
    capture = 1'b1;
    drainIf.out_ready = 1'b1;
    while ((sbq.size() != 0 || !second) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      capture = 1'b0;
      if (cyc == NW + 1) begin
        nChecks++;
        if ({drainIf.out_valid, busy} !== 2'b00) begin
          nFails++;
          $display("[TB] FAIL b2b_gap: got valid/busy=%b expected 00", {drainIf.out_valid, busy});
        end
        fill_high();
        push_frame();
        capture = 1'b1;
        second = 1'b1;
      end else begin
        nChecks++;
        if ({arrayClr, overrun} !== {(cyc == 1) || (cyc == NW + 2), 1'b0}) begin
          nFails++;
          $display("[TB] FAIL b2b_flags cyc%0d: got clr/ovr=%b%b expected %b0",
                   cyc, arrayClr, overrun, (cyc == 1) || (cyc == NW + 2));
        end
        if (cyc == NW + 2) begin
          nChecks++;
          if (drainIf.out_valid !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL b2b_start: got valid=%b expected 1", drainIf.out_valid);
          end
        end
        if (drainIf.out_valid && drainIf.out_ready) begin
          e = sbq.pop_front();
          nChecks++;
          if ({drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last} !==
              {e.data, e.row, e.col, e.last}) begin
            nFails++;
            $display("[TB] FAIL b2b_word cyc%0d: got %h r%0d c%0d last=%b expected %h r%0d c%0d last=%b",
                     cyc, drainIf.out_data, drainIf.out_row, drainIf.out_col, drainIf.out_last,
                     e.data, e.row, e.col, e.last);
          end
        end
      end
    end
    nChecks++;
    if (sbq.size() != 0 || cyc != 2*NW + 1) begin
      nFails++;
      $display("[TB] FAIL b2b_timing: got %0d words left after %0d cycles expected 0 after %0d",
               sbq.size(), cyc, 2*NW + 1);
      sbq.delete();
    end
    @(negedge clk);
    nChecks++;
    if ({drainIf.out_valid, overrun} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL b2b_end: got valid/ovr=%b expected 00", {drainIf.out_valid, overrun});
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    rst = 1'b1;
    capture = 1'b0;
    cIn = '0;
    drainIf.out_ready = 1'b0;
    $display("[TB] starting systolic_result_drain bench");
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_snapshot_isolation();
    test_overrun();
    test_reset_mid_stream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Guards against a stuck simulation if any loop bound were ever defeated.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected end before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
